// File: rtl/pdl_measure.sv
// Pulse measurement for the programmable delay line: counts trigger-to-pulse delay and pulse width,
// then offers both counts (plus timeout/saturation flags) to a consumer over a valid/ready handshake.
module pdl_measure #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_timeout,
    output logic             meas_wsat,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             busy,
    output logic [15:0]      drop_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        IN_PULSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WMAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             trig_q;
    logic             pulse_q;

    logic trig_rise;
    logic pulse_rise;
    logic accept;
    logic drop;

    assign trig_rise  = trigger & ~trig_q;
    assign pulse_rise = pulse_in & ~pulse_q;

    // Handshake: a result is offered while meas_valid is high and is consumed on the first
    // rising edge where meas_valid & meas_ready; the result fields do not change until then.
    assign accept = trig_rise & ((state_q == IDLE) | ((state_q == DONE) & meas_ready));
    assign drop   = trig_rise & ((state_q == WAIT) | (state_q == IN_PULSE) |
                                 ((state_q == DONE) & ~meas_ready));

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            meas_delay   <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
            meas_wsat    <= 1'b0;
            meas_valid   <= 1'b0;
            busy         <= 1'b0;
            drop_cnt     <= '0;
            // Load current levels so an input held high through reset is not seen as a rise.
            trig_q       <= trigger;
            pulse_q      <= pulse_in;
        end else begin
            trig_q  <= trigger;
            pulse_q <= pulse_in;

            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            case (state_q)
                IDLE: begin
                end
                WAIT: begin
                    if (pulse_rise) begin
                        meas_delay <= cnt_q;
                        wcnt_q     <= ONE;
                        state_q    <= IN_PULSE;
                    end else if (cnt_q == TO_V) begin
                        meas_delay   <= TO_V;
                        meas_width   <= '0;
                        meas_timeout <= 1'b1;
                        meas_valid   <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                IN_PULSE: begin
                    if (pulse_in) begin
                        if (wcnt_q != WMAX) begin
                            wcnt_q <= wcnt_q + ONE;
                        end
                        if (wcnt_q >= WMAX - ONE) begin
                            meas_wsat <= 1'b1;
                        end
                    end else begin
                        // Also covers a 1-bit counter that starts already saturated.
                        if (wcnt_q == WMAX) begin
                            meas_wsat <= 1'b1;
                        end
                        meas_width <= wcnt_q;
                        meas_valid <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (meas_ready) begin
                        meas_valid   <= 1'b0;
                        meas_timeout <= 1'b0;
                        meas_wsat    <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A trigger accepted while leaving DONE overrides the return to IDLE above.
            if (accept) begin
                busy <= 1'b1;
                if (pulse_rise) begin
                    meas_delay <= '0;
                    wcnt_q     <= ONE;
                    state_q    <= IN_PULSE;
                end else begin
                    cnt_q   <= ONE;
                    state_q <= WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdl_measure.sv
// Bench for pdl_measure: two instances (wide counters / 4-bit counters) share one stimulus stream;
// a cycle-stamped reference model predicts results, a negedge monitor checks every output.
module tb_pdl_measure;

    typedef struct {
        longint d;
        longint w;
        bit     to;
        bit     ws;
    } res_t;

    logic clk;
    logic reset;
    logic trigger;
    logic pulse_in;
    logic meas_ready;
    bit   rdy_rand;
    event end_ev;

    int n_cmp;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int     CW   = (g == 0) ? 16 : 4;
        localparam int     TO   = (g == 0) ? 20 : 15;
        localparam longint MAXV = (longint'(1) << CW) - 1;

        logic [CW-1:0] meas_delay;
        logic [CW-1:0] meas_width;
        logic          meas_timeout;
        logic          meas_wsat;
        logic          meas_valid;
        logic          busy;
        logic [15:0]   drop_cnt;
        logic [1:0]    dbg_state;

        pdl_measure #(.CNT_W(CW), .TIMEOUT(TO)) dut (
            .clk         (clk),
            .reset       (reset),
            .trigger     (trigger),
            .pulse_in    (pulse_in),
            .meas_delay  (meas_delay),
            .meas_width  (meas_width),
            .meas_timeout(meas_timeout),
            .meas_wsat   (meas_wsat),
            .meas_valid  (meas_valid),
            .meas_ready  (meas_ready),
            .busy        (busy),
            .drop_cnt    (drop_cnt),
            .dbg_state   (dbg_state)
        );

        // Reference model: phase 0 idle, 1 waiting for pulse, 2 in pulse, 3 result pending.
        res_t   exp_q[$];
        res_t   cur;
        int     ph = 0;
        longint cyc = 0;
        longint t0 = 0;
        longint t1 = 0;
        longint w = 0;
        int     drop = 0;
        bit     ptrig = 0;
        bit     ppulse = 0;
        bit     rst_last = 0;
        bit     started = 0;
        bit     pvalid = 0;
        bit     tr;
        bit     pr;

        always @(posedge clk) begin
            cyc++;
            started = 1;
            if (reset) begin
                ph       = 0;
                drop     = 0;
                rst_last = 1;
            end else begin
                rst_last = 0;
                tr = trigger && !ptrig;
                pr = pulse_in && !ppulse;
                if (tr && (ph == 1 || ph == 2 || (ph == 3 && !meas_ready)) && drop < 65535)
                    drop++;
                case (ph)
                    1: begin
                        if (pr) begin
                            t1 = cyc;
                            ph = 2;
                        end else if (cyc - t0 == TO) begin
                            exp_q.push_back('{d: TO, w: 0, to: 1'b1, ws: 1'b0});
                            ph = 3;
                        end
                    end
                    2: begin
                        if (!pulse_in) begin
                            w = cyc - t1;
                            exp_q.push_back('{d: t1 - t0, w: (w > MAXV) ? MAXV : w,
                                              to: 1'b0, ws: (w >= MAXV)});
                            ph = 3;
                        end
                    end
                    3: if (meas_ready) ph = 0;
                    default: ;
                endcase
                if (tr && ph == 0) begin
                    t0 = cyc;
                    if (pr) begin
                        t1 = cyc;
                        ph = 2;
                    end else begin
                        ph = 1;
                    end
                end
            end
            ptrig  = trigger;
            ppulse = pulse_in;
        end

        always @(negedge clk) begin
            if (started) begin
                chk("valid", g, 64'(meas_valid), 64'(ph == 3));
                chk("busy", g, 64'(busy), 64'(ph == 1 || ph == 2));
                chk("drop_cnt", g, 64'(drop_cnt), 64'(drop));
                chk("state", g, 64'(dbg_state), 64'(ph));
                if (meas_valid && !pvalid) begin
                    chk("result_expected", g, 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                end
                if (meas_valid) begin
                    chk("meas_delay", g, 64'(meas_delay), cur.d);
                    chk("meas_width", g, 64'(meas_width), cur.w);
                    chk("meas_timeout", g, 64'(meas_timeout), 64'(cur.to));
                    chk("meas_wsat", g, 64'(meas_wsat), 64'(cur.ws));
                end
                if (rst_last) begin
                    chk("rst_delay", g, 64'(meas_delay), 64'(0));
                    chk("rst_width", g, 64'(meas_width), 64'(0));
                    chk("rst_timeout", g, 64'(meas_timeout), 64'(0));
                    chk("rst_wsat", g, 64'(meas_wsat), 64'(0));
                end
                pvalid = meas_valid;
            end
        end

        always @(end_ev) begin
            chk("unseen_results", g, 64'(exp_q.size()), 64'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pdl-style shot: trigger high for tl cycles, pulse rises dl cycles after it for wb cycles.
    task automatic shot(input int dl, input int wb, input int tl);
        int n;
        n = ((tl > dl + wb) ? tl : dl + wb) + 2;
        for (int i = 0; i < n; i++) begin
            trigger  = (i < tl);
            pulse_in = (i >= dl) && (i < dl + wb);
            tick();
        end
        trigger  = 1'b0;
        pulse_in = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) meas_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rdy_rand   = 1'b0;
        trigger    = 1'b0;
        pulse_in   = 1'b0;
        meas_ready = 1'b1;
        reset      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        shot(8, 5, 10);
        repeat (3) tick();
        shot(0, 3, 3);
        repeat (3) tick();
        shot(30, 0, 2);
        repeat (3) tick();

        meas_ready = 1'b0;
        shot(8, 5, 10);
        for (int i = 0; i < 50; i++) begin
            trigger = (i >= 10 && i < 13) || (i >= 30 && i < 32);
            tick();
        end
        trigger    = 1'b0;
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        repeat (3) tick();
        meas_ready = 1'b1;
        repeat (2) tick();

        shot(2, 20, 2);
        repeat (3) tick();
        shot(1, 14, 2);
        repeat (3) tick();

        trigger = 1'b1;
        repeat (2) tick();
        pulse_in = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        trigger  = 1'b0;
        pulse_in = 1'b0;
        repeat (3) tick();
        shot(4, 6, 2);
        repeat (3) tick();

        rdy_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            shot($urandom_range(0, 24), $urandom_range(0, 22), $urandom_range(1, 12));
            repeat ($urandom_range(1, 6)) tick();
        end
        rdy_rand   = 1'b0;
        meas_ready = 1'b1;
        repeat (40) tick();

        -> end_ev;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pdl_measure.md
# pdl_measure

Pulse measurement block that receives the output of the programmable delay line and recovers its settings. On each accepted `trigger` rising edge it counts clock cycles until `pulse_in` rises (the delay) and then cycles while `pulse_in` stays high (the width). It presents both counts with a valid/ready handshake, so a host or self-test can close the loop on `pdl` (`dl`, `wb` in, `delay_out` back in).

## Interface
- `CNT_W`, default 32: width of the delay and width counters and result buses.
- `TIMEOUT`, default 1000000: maximum delay count before a measurement is aborted; must be ≥1 and ≤ 2^CNT_W−1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `trigger`  in  1  start strobe, same signal that drives `pdl`; synchronous to `clk`.
- `pulse_in`  in  1  pulse under measurement (`pdl.delay_out`); synchronous to `clk`.
- `meas_delay`  out  CNT_W  cycles from trigger rise to pulse rise.
- `meas_width`  out  CNT_W  cycles `pulse_in` was sampled high.
- `meas_timeout`  out  1  result flag: no pulse rise within TIMEOUT cycles.
- `meas_wsat`  out  1  result flag: width counter saturated at 2^CNT_W−1.
- `meas_valid`  out  1  result registers are valid.
- `meas_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in WAIT and IN_PULSE.
- `drop_cnt`  out  16  saturating count of trigger rises that were ignored.

## Operation
- Edge detect: `trig_q` and `pulse_q` hold the previous samples. A rise is `x & ~x_q`. During reset, `trig_q` and `pulse_q` load the current inputs, so a level held high through reset is not an edge.
- States: IDLE, WAIT, IN_PULSE, DONE.
- IDLE:
  - Trigger rise with no pulse rise: `cnt <= 1`, go to WAIT.
  - Trigger rise and pulse rise on the same edge: `meas_delay <= 0`, `wcnt <= 1`, go to IN_PULSE.
  - A pulse rise without a trigger rise is ignored.
- WAIT:
  - Pulse rise: `meas_delay <= cnt`, `wcnt <= 1`, go to IN_PULSE.
  - Otherwise, if `cnt == TIMEOUT`: `meas_delay <= TIMEOUT`, `meas_width <= 0`, `meas_timeout <= 1`, `meas_valid <= 1`, go to DONE.
  - Otherwise: `cnt <= cnt + 1`.
  - If `pulse_in` is already high on entry, it does not count; WAIT needs a fresh rise.
- IN_PULSE:
  - `pulse_in == 1`: `wcnt <= wcnt + 1`, saturating at 2^CNT_W−1. Reaching saturation sets `meas_wsat`, and the block keeps waiting for the fall.
  - `pulse_in == 0`: `meas_width <= wcnt`, `meas_valid <= 1`, go to DONE.
- DONE:
  - Results are held stable while `meas_valid & ~meas_ready`.
  - On an edge with `meas_ready == 1`: `meas_valid <= 0`, clear `meas_timeout` and `meas_wsat`, go to IDLE.
  - If a trigger rise occurs on that same edge, it is accepted as in IDLE: go directly to WAIT (or to IN_PULSE on a simultaneous pulse rise).
- Dropped triggers:
  - A trigger rise in WAIT or IN_PULSE increments `drop_cnt`.
  - A trigger rise in DONE without `meas_ready` also increments `drop_cnt`.
  - `drop_cnt` saturates at 16'hFFFF and clears only on reset.
- Arithmetic: all counters are unsigned CNT_W bits. `meas_delay` is at most TIMEOUT.

## Timing
- Reset values:
  - State IDLE.
  - `meas_delay`, `meas_width`, `meas_timeout`, `meas_wsat`, `meas_valid`, `busy`, `drop_cnt` all 0.
  - `cnt` and `wcnt` are 0.
- Reset mid-measurement aborts with no result and no handshake.
- Counting reference: T0 is the edge that samples the trigger rise, T1 the edge that samples the pulse rise, T2 the first edge that samples `pulse_in == 0` after T1.
  - `meas_delay = T1 − T0`.
  - `meas_width = T2 − T1`.
  - A `pdl` programmed with `dl = N`, `wb = M` reads back as N and M.
- `meas_valid` rises on edge T2 and is visible the cycle after T2.
- Timeout: `meas_valid` is asserted at edge T0 + TIMEOUT.
- `busy` is registered: high from the cycle after T0 to the cycle of T2 inclusive.
- Minimum turnaround: with `meas_ready` held high, a new trigger is accepted one cycle after `meas_valid` rises.

## Test plan
- Basic readback:
  - Stimulus: `pdl` with `dl=8`, `wb=5`, trigger pulse high 10 cycles; `pulse_in = delay_out`; `meas_ready = 1`.
  - Required: `meas_delay=8`, `meas_width=5`, `meas_timeout=0`, `meas_wsat=0`; `meas_valid` high exactly 1 cycle.
- Zero delay:
  - Stimulus: `trigger` and `pulse_in` rise on the same cycle; `pulse_in` high 3 cycles.
  - Required: `meas_delay=0`, `meas_width=3`.
- Timeout:
  - Stimulus: TIMEOUT=20, trigger with no pulse.
  - Required: `meas_valid` rises 20 cycles after T0; `meas_timeout=1`, `meas_delay=20`, `meas_width=0`.
- Backpressure:
  - Stimulus: `meas_ready = 0` for 50 cycles after a result, with 2 trigger rises in that window.
  - Required: results held unchanged; `drop_cnt = 2`; after `meas_ready` pulses high, `meas_valid = 0` and state is IDLE.
- Width saturation:
  - Stimulus: CNT_W=4, `pulse_in` held high 20 cycles.
  - Required: `meas_width = 15`, `meas_wsat = 1`.
- Reset mid-operation:
  - Stimulus: `reset` asserted in IN_PULSE while `trigger` and `pulse_in` are held high.
  - Required: all outputs 0 next cycle; no false measurement starts after reset release until a fresh trigger rise.
